// File: rtl/i2s_master_rx_if.sv
// Frame bus between the I2S receiver and the downstream streaming logic.
// Carries the serial inputs, the generated clocks and the captured stereo words.
interface i2s_master_rx_if #(
  parameter int WIDTH = 24
);
  logic             din0;
  logic             din1;
  logic             i2s_bclk;
  logic             i2s_wclk;
  logic [WIDTH-1:0] data0L;
  logic [WIDTH-1:0] data0R;
  logic [WIDTH-1:0] data1L;
  logic [WIDTH-1:0] data1R;
  logic             sample_valid;
  logic [7:0]       frame_id;

  modport master (
    input  din0, din1,
    output i2s_bclk, i2s_wclk, data0L, data0R, data1L, data1R, sample_valid, frame_id
  );

  modport slave (
    output din0, din1,
    input  i2s_bclk, i2s_wclk, data0L, data0R, data1L, data1R, sample_valid, frame_id
  );
endinterface

// File: rtl/i2s_master_rx.sv
// I2S master receiver: generates bclk/wclk from adc_clk and deserialises two
// stereo lines, presenting one coherent L/R frame per word-clock period.
module i2s_master_rx #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic            adc_clk,
  input  logic            rst_n,
  i2s_master_rx_if.master bus
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2*SLOT_BITS);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV-1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV/2);
  localparam logic [DW-1:0] DIV_RISE = DW'(BCLK_DIV/2-1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_BITS-1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
  localparam logic [BW-1:0] WID      = BW'(WIDTH);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bclk_q, bclk_d, wclk_q, wclk_d;
  logic [1:0][1:0][WIDTH-1:0] sh_q, sh_d;     // [line][0=left,1=right]
  logic [1:0][WIDTH-1:0]      stage_q, stage_d;
  logic [1:0][WIDTH-1:0]      dl_q, dr_q, nxt;
  logic          pend_q, pend_d, valid_q;
  logic [7:0]    fid_q;
  logic [BW-1:0] slot_bit;
  logic [1:0]    din;
  logic          rise, right, take, last;

  assign din = {bus.din1, bus.din0};

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_ONE;
    bit_cnt_d = bit_cnt_q;
    if (div_cnt_q == DIV_LAST)
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_ONE;
    bclk_d = (div_cnt_d >= DIV_HALF);
    wclk_d = (bit_cnt_d >= SLOT);

    // Sample on the edge that raises bclk; slot bit 0 is the I2S delay bit.
    rise     = (div_cnt_q == DIV_RISE);
    right    = (bit_cnt_q >= SLOT);
    slot_bit = right ? bit_cnt_q - SLOT : bit_cnt_q;
    take     = rise && (slot_bit >= BIT_ONE) && (slot_bit <= WID);
    last     = rise && (slot_bit == WID);

    sh_d    = sh_q;
    stage_d = stage_q;
    nxt     = '0;
    for (int l = 0; l < 2; l++) begin
      nxt[l] = {sh_q[l][right][WIDTH-2:0], din[l]};
      if (take) sh_d[l][right] = nxt[l];
      if (last && !right) stage_d[l] = nxt[l];
    end
    pend_d = last && right;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      wclk_q    <= 1'b0;
      sh_q      <= '0;
      stage_q   <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      fid_q     <= '0;
      dl_q      <= '0;
      dr_q      <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      wclk_q    <= wclk_d;
      sh_q      <= sh_d;
      stage_q   <= stage_d;
      pend_q    <= pend_d;
      valid_q   <= pend_q;
      // Left comes from staging so L and R always belong to the same frame.
      if (pend_q) begin
        for (int l = 0; l < 2; l++) begin
          dl_q[l] <= stage_q[l];
          dr_q[l] <= sh_q[l][1];
        end
        fid_q <= fid_q + 8'd1;
      end
    end
  end

  assign bus.i2s_bclk     = bclk_q;
  assign bus.i2s_wclk     = wclk_q;
  assign bus.data0L       = dl_q[0];
  assign bus.data1L       = dl_q[1];
  assign bus.data0R       = dr_q[0];
  assign bus.data1R       = dr_q[1];
  assign bus.sample_valid = valid_q;
  assign bus.frame_id     = fid_q;
endmodule

// File: tb/tb_i2s_master_rx.sv
// Directed bench for i2s_master_rx: an ADC model serialises words from a
// free-running cycle count, and each task checks one behaviour inline.
module tb_i2s_master_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ncyc;
  logic [23:0] l0 = '0, r0 = '0, l1 = '0, r1 = '0;
  logic        pad = 1'b0;

  always #5 clk = ~clk;

  i2s_master_rx_if #(.WIDTH(24)) bus ();

  i2s_master_rx #(.WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
    .adc_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus.master)
  );

  // ncyc = number of adc_clk edges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  // Bit for the next sampling edge 4k+2 is bit k of the 64-bit frame.
  function automatic logic ser(input int n, input logic [23:0] lw, input logic [23:0] rw,
                               input logic p);
    int b, s;
    logic [23:0] w;
    b = ((n + 1) / 4) % 64;
    s = b % 32;
    w = (b >= 32) ? rw : lw;
    if (s >= 1 && s <= 24) return w[24-s];
    return p;
  endfunction

  assign bus.din0 = ser(ncyc, l0, r0, pad);
  assign bus.din1 = ser(ncyc, l1, r1, pad);

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    l0 = 24'hABCDEF; r0 = 24'h123456; l1 = 24'h0F0F0F; r1 = 24'hF0F0F0; pad = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.i2s_bclk, bus.i2s_wclk, bus.sample_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got %b want 000", {bus.i2s_bclk, bus.i2s_wclk, bus.sample_valid});
    end
    checks++;
    if ({bus.data0L, bus.data0R, bus.data1L, bus.data1R} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {bus.data0L, bus.data0R, bus.data1L, bus.data1R});
    end
    checks++;
    if (bus.frame_id !== 8'd0) begin
      errors++; $display("FAIL reset_fid got %0d want 0", bus.frame_id);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clocks;
    int bad;
    logic eb, ew;
    bad = 0;
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      eb = ((ncyc % 4) >= 2);
      ew = (((ncyc / 4) % 64) >= 32);
      checks++;
      if (bus.i2s_bclk !== eb || bus.i2s_wclk !== ew) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL clocks at cyc %0d got bclk=%b wclk=%b want bclk=%b wclk=%b",
                   ncyc, bus.i2s_bclk, bus.i2s_wclk, eb, ew);
      end
    end
  endtask

  task automatic test_pattern;
    bit ok;
    wait_valid(100, ok);
    checks++;
    if (!ok || ncyc !== 227) begin
      errors++; $display("FAIL pattern_time got ok=%0d cyc=%0d want cyc 227", ok, ncyc);
    end
    checks++;
    if (bus.data0L !== 24'hABCDEF || bus.data0R !== 24'h123456) begin
      errors++; $display("FAIL pattern_line0 got %h/%h want abcdef/123456", bus.data0L, bus.data0R);
    end
    checks++;
    if (bus.data1L !== 24'h0F0F0F || bus.data1R !== 24'hF0F0F0) begin
      errors++; $display("FAIL pattern_line1 got %h/%h want 0f0f0f/f0f0f0", bus.data1L, bus.data1R);
    end
    checks++;
    if (bus.frame_id !== 8'd1) begin
      errors++; $display("FAIL pattern_fid got %0d want 1", bus.frame_id);
    end
    @(negedge clk);
    checks++;
    if (bus.sample_valid !== 1'b0) begin
      errors++; $display("FAIL pattern_pulse got valid=%b want 0", bus.sample_valid);
    end
  endtask

  task automatic test_padding;
    bit ok;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0; pad = 1'b1;
    wait_valid(300, ok);
    checks++;
    if (!ok || ncyc !== 483) begin
      errors++; $display("FAIL pad_time got ok=%0d cyc=%0d want cyc 483", ok, ncyc);
    end
    checks++;
    if ({bus.data0L, bus.data0R, bus.data1L, bus.data1R} !== 96'h0) begin
      errors++; $display("FAIL pad_data got %h want 0", {bus.data0L, bus.data0R, bus.data1L, bus.data1R});
    end
    checks++;
    if (bus.frame_id !== 8'd2) begin
      errors++; $display("FAIL pad_fid got %0d want 2", bus.frame_id);
    end
  endtask

  task automatic test_coherency;
    int bad;
    bit seen;
    bad = 0; seen = 1'b0;
    l0 = 24'h5A5A5A; l1 = 24'hA5A5A5;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.sample_valid) seen = 1'b1;
      else if ({bus.data0L, bus.data1L, bus.data0R, bus.data1R} !== 96'h0) begin
        bad++;
        if (bad < 5) $display("FAIL coh_hold at cyc %0d got L=%h/%h want 0", ncyc, bus.data0L, bus.data1L);
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (!seen || ncyc !== 739) begin
      errors++; $display("FAIL coh_time got seen=%0d cyc=%0d want cyc 739", seen, ncyc);
    end
    checks++;
    if (bus.data0L !== 24'h5A5A5A || bus.data1L !== 24'hA5A5A5) begin
      errors++; $display("FAIL coh_left got %h/%h want 5a5a5a/a5a5a5", bus.data0L, bus.data1L);
    end
    checks++;
    if (bus.data0R !== 24'h0 || bus.data1R !== 24'h0) begin
      errors++; $display("FAIL coh_right got %h/%h want 0/0", bus.data0R, bus.data1R);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int prev, bad;
    logic [7:0] exp_id;
    prev = ncyc; exp_id = 8'd3; bad = 0;
    for (int f = 0; f < 253; f++) begin
      wait_valid(300, ok);
      exp_id = exp_id + 8'd1;
      checks++;
      if (!ok || (ncyc - prev) !== 256 || bus.frame_id !== exp_id) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL wrap frame %0d got ok=%0d gap=%0d fid=%0d want gap 256 fid %0d",
                              f, ok, ncyc - prev, bus.frame_id, exp_id);
        if (!ok) break;
      end
      prev = ncyc;
    end
    checks++;
    if (bus.frame_id !== 8'd0) begin
      errors++; $display("FAIL wrap_final got fid=%0d want 0", bus.frame_id);
    end
  endtask

  task automatic test_mid_reset;
    bit ok, hit, spur;
    hit = 1'b0; spur = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if ((ncyc % 256) == 170) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL midrst_reach got no right-slot bit 10 point");
    end
    l0 = 24'h111111; r0 = 24'h222222; l1 = 24'h333333; r1 = 24'h444444; pad = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.data0L, bus.data0R, bus.data1L, bus.data1R} !== 96'h0 || bus.frame_id !== 8'd0) begin
      errors++; $display("FAIL midrst_async got data=%h fid=%0d want 0", {bus.data0L, bus.data0R}, bus.frame_id);
    end
    checks++;
    if ({bus.i2s_bclk, bus.i2s_wclk, bus.sample_valid} !== 3'b000) begin
      errors++; $display("FAIL midrst_ctl got %b want 000", {bus.i2s_bclk, bus.i2s_wclk, bus.sample_valid});
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.sample_valid) spur = 1'b1;
    end
    rst_n = 1'b1;
    wait_valid(300, ok);
    checks++;
    if (spur || !ok || ncyc !== 227) begin
      errors++; $display("FAIL midrst_time got spur=%0d ok=%0d cyc=%0d want cyc 227", spur, ok, ncyc);
    end
    checks++;
    if (bus.data0L !== 24'h111111 || bus.data0R !== 24'h222222 ||
        bus.data1L !== 24'h333333 || bus.data1R !== 24'h444444) begin
      errors++; $display("FAIL midrst_data got %h %h %h %h want 111111 222222 333333 444444",
                         bus.data0L, bus.data0R, bus.data1L, bus.data1R);
    end
    checks++;
    if (bus.frame_id !== 8'd1) begin
      errors++; $display("FAIL midrst_fid got %0d want 1", bus.frame_id);
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_pattern();
    test_padding();
    test_coherency();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
